// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control block: FSM encodings and
// default timing constants for a 50 MHz system clock.
package stopwatch_pkg;

    // 20 ms debounce window at 50 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    // 10 ms count period at 50 MHz.
    localparam int DEFAULT_TICK_CYCLES     = 500000;

    // Run-state encoding; 2'b11 is never entered and falls back to idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } run_state_t;

endpackage

// File: rtl/key_debounce.sv
// One board key: 2-flop synchronizer, stability debounce and press-edge
// detection. The key is active-low; "level" is the accepted (debounced)
// level and "press" is a single-cycle pulse on an accepted 1->0 change.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             level_q;

    // Bring the raw key into the clock domain; idle (released) level is 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES
    // consecutive cycles; any return to the accepted level restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b1;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered falling-edge detect on the accepted level; releases are silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b1;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level_q & ~level;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounces three keys, runs the idle/run/pause FSM,
// generates the counter tick and clear pulses and the display-freeze flag.
// The exposed run_state is the FSM state register itself.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES     = DEFAULT_TICK_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_reset_n,
    input  logic       key_start_pause_n,
    input  logic       key_display_stop_n,
    output logic       count_tick,
    output logic       counter_clear,
    output logic       display_follow,
    output logic [1:0] run_state,
    output logic [3:0] led
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

    logic              reset_ev;
    logic              start_ev;
    logic              disp_ev;
    logic              reset_lvl;
    logic              start_lvl;
    logic              disp_lvl;
    run_state_t        state;
    run_state_t        state_next;
    logic              follow_next;
    logic [TICK_W-1:0] tick_cnt;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_reset (
        .clk   (clk),
        .reset (reset),
        .key_n (key_reset_n),
        .level (reset_lvl),
        .press (reset_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .clk   (clk),
        .reset (reset),
        .key_n (key_start_pause_n),
        .level (start_lvl),
        .press (start_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_display (
        .clk   (clk),
        .reset (reset),
        .key_n (key_display_stop_n),
        .level (disp_lvl),
        .press (disp_ev)
    );

    // Next state and display flag; a reset event overrides start and display.
    always_comb begin
        state_next  = state;
        follow_next = display_follow;
        if (reset_ev) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start_ev) state_next = ST_RUN;
                ST_RUN:   if (start_ev) state_next = ST_PAUSE;
                ST_PAUSE: if (start_ev) state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
        if (reset_ev) begin
            follow_next = 1'b1;
        end else if (disp_ev) begin
            follow_next = ~display_follow;
        end
    end

    // FSM, tick divider and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            tick_cnt       <= '0;
            count_tick     <= 1'b0;
            counter_clear  <= 1'b0;
            display_follow <= 1'b1;
            led            <= 4'b0000;
        end else begin
            state          <= state_next;
            display_follow <= follow_next;
            counter_clear  <= reset_ev;
            count_tick     <= 1'b0;
            // Pause leaves tick_cnt untouched so the partial period resumes.
            if (reset_ev || state == ST_IDLE) begin
                tick_cnt <= '0;
            end else if (state == ST_RUN) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt   <= '0;
                    count_tick <= 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
            led <= {~(reset_lvl & start_lvl & disp_lvl),
                    ~follow_next,
                    state_next == ST_PAUSE,
                    state_next == ST_RUN};
        end
    end

    assign run_state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=5.
// Inputs change and outputs are sampled on the falling clock edge. A key
// lowered at a falling edge gives its FSM effect 8 rising edges later.
module tb_stopwatch_ctrl;

    localparam int DEB = 4;
    localparam int TCK = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       key_reset_n = 1'b1;
    logic       key_start_pause_n = 1'b1;
    logic       key_display_stop_n = 1'b1;
    logic       count_tick;
    logic       counter_clear;
    logic       display_follow;
    logic [1:0] run_state;
    logic [3:0] led;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_CYCLES(TCK)) dut (
        .clk                (clk),
        .reset              (reset),
        .key_reset_n        (key_reset_n),
        .key_start_pause_n  (key_start_pause_n),
        .key_display_stop_n (key_display_stop_n),
        .count_tick         (count_tick),
        .counter_clear      (counter_clear),
        .display_follow     (display_follow),
        .run_state          (run_state),
        .led                (led)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tick"},   32'(count_tick),     32'd0);
        check({tag, "_clr"},    32'(counter_clear),  32'd0);
        check({tag, "_follow"}, 32'(display_follow), 32'd1);
        check({tag, "_state"},  32'(run_state),      32'd0);
        check({tag, "_led"},    32'(led),            32'd0);
    endtask

    task automatic hw_reset();
        reset = 1'b1;
        key_reset_n = 1'b1;
        key_start_pause_n = 1'b1;
        key_display_stop_n = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // From IDLE: press start, return right after the edge that enters RUN
    // (reference point s=0 of the callers), key released there.
    task automatic start_run();
        key_start_pause_n = 1'b0;
        repeat (8) step();
        key_start_pause_n = 1'b1;
    endtask

    // Press a key combination simultaneously, then release and let it settle.
    task automatic press_keys(input logic r, input logic s, input logic d);
        key_reset_n = ~r;
        key_start_pause_n = ~s;
        key_display_stop_n = ~d;
        repeat (8) step();
        key_reset_n = 1'b1;
        key_start_pause_n = 1'b1;
        key_display_stop_n = 1'b1;
        repeat (8) step();
    endtask

    initial begin
        // asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        step();
        reset = 1'b0;

        // no spurious events with keys released
        repeat (10) step();
        check_reset_outputs("idle_quiet");

        // single held press: RUN after 8 edges, ticks every 5 edges
        key_start_pause_n = 1'b0;
        for (int s = 1; s <= 30; s++) begin
            step();
            check("t1_tick", 32'(count_tick), 32'(s > 8 && (s - 8) % TCK == 0));
            if (s == 7) check("t1_state_pre", 32'(run_state), 32'd0);
            if (s >= 8) check("t1_state_run", 32'(run_state), 32'd1);
            if (s == 8) check("t1_led_held", 32'(led), 32'b1001);
            if (s == 30) check("t1_led_rel", 32'(led), 32'b0001);
            if (s == 20) key_start_pause_n = 1'b1;
        end

        // bounce 0-1-0-1 (2 cycles each) then hold low
        hw_reset();
        for (int b = 0; b < 4; b++) begin
            key_start_pause_n = b[0];
            step();
            step();
            check("t2_bounce_state", 32'(run_state), 32'd0);
        end
        key_start_pause_n = 1'b0;
        for (int s = 1; s <= 10; s++) begin
            step();
            check("t2_state", 32'(run_state), 32'(s >= 8 ? 1 : 0));
        end
        key_start_pause_n = 1'b1;

        // pause holds the partial tick period
        hw_reset();
        start_run();
        for (int s = 1; s <= 40; s++) begin
            step();
            check("t3_tick", 32'(count_tick), 32'(s == 5 || s == 10 || s == 15 || s == 38));
            check("t3_state", 32'(run_state), 32'((s >= 17 && s <= 34) ? 2 : 1));
            if (s == 9)  key_start_pause_n = 1'b0;
            if (s == 17) key_start_pause_n = 1'b1;
            if (s == 27) key_start_pause_n = 1'b0;
            if (s == 35) key_start_pause_n = 1'b1;
        end

        // reset event would coincide with a tick: clear wins
        hw_reset();
        start_run();
        for (int s = 1; s <= 24; s++) begin
            step();
            check("t4_tick", 32'(count_tick), 32'(s == 5 || s == 10 || s == 15));
            if (s == 19) check("t4_state_pre", 32'(run_state), 32'd1);
            if (s == 20) check("t4_state_idle", 32'(run_state), 32'd0);
            if (s >= 19 && s <= 21) check("t4_clr", 32'(counter_clear), 32'(s == 20));
            if (s == 12) key_reset_n = 1'b0;
            if (s == 20) key_reset_n = 1'b1;
        end

        // start+display together, then reset+start together in PAUSE
        hw_reset();
        start_run();
        for (int s = 1; s <= 36; s++) begin
            step();
            check("t5_tick", 32'(count_tick), 32'(s == 5 || s == 10 || s == 15));
            if (s == 16) check("t5_state_pause", 32'(run_state), 32'd2);
            if (s == 16) check("t5_follow_off", 32'(display_follow), 32'd0);
            if (s == 31) check("t5_state_pre", 32'(run_state), 32'd2);
            if (s >= 31 && s <= 33) check("t5_clr", 32'(counter_clear), 32'(s == 32));
            if (s == 32) check("t5_state_idle", 32'(run_state), 32'd0);
            if (s == 32) check("t5_follow_on", 32'(display_follow), 32'd1);
            if (s == 8) begin
                key_start_pause_n = 1'b0;
                key_display_stop_n = 1'b0;
            end
            if (s == 16) begin
                key_start_pause_n = 1'b1;
                key_display_stop_n = 1'b1;
            end
            if (s == 24) begin
                key_reset_n = 1'b0;
                key_start_pause_n = 1'b0;
            end
            if (s == 32) begin
                key_reset_n = 1'b1;
                key_start_pause_n = 1'b1;
            end
        end

        // display toggles in RUN without disturbing ticks
        hw_reset();
        start_run();
        for (int s = 1; s <= 32; s++) begin
            step();
            check("t6_tick", 32'(count_tick), 32'(s % TCK == 0));
            if (s == 8)  check("t6_follow_a", 32'(display_follow), 32'd1);
            if (s == 9)  check("t6_follow_b", 32'(display_follow), 32'd0);
            if (s == 9)  check("t6_led_b", 32'(led), 32'b1101);
            if (s == 17) check("t6_led_c", 32'(led), 32'b0101);
            if (s == 27) check("t6_follow_c", 32'(display_follow), 32'd0);
            if (s == 28) check("t6_follow_d", 32'(display_follow), 32'd1);
            if (s == 1 || s == 20) key_display_stop_n = 1'b0;
            if (s == 9 || s == 28) key_display_stop_n = 1'b1;
        end

        // reset+display together forces follow to 1 (a toggle would give 0)
        hw_reset();
        press_keys(1'b0, 1'b0, 1'b1);
        check("t7_follow_off", 32'(display_follow), 32'd0);
        check("t7_led_off", 32'(led), 32'b0100);
        press_keys(1'b0, 1'b0, 1'b1);
        check("t7_follow_on", 32'(display_follow), 32'd1);
        press_keys(1'b1, 1'b0, 1'b1);
        check("t7_follow_rst", 32'(display_follow), 32'd1);
        check("t7_state", 32'(run_state), 32'd0);

        // hardware reset mid-debounce and on a tick cycle
        hw_reset();
        start_run();
        for (int s = 1; s <= 5; s++) begin
            step();
            if (s == 2) key_display_stop_n = 1'b0;
        end
        check("t8_tick_pre", 32'(count_tick), 32'd1);
        reset = 1'b1;
        #1 check_reset_outputs("t8_async");
        key_display_stop_n = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int s = 1; s <= 20; s++) begin
            step();
            check("t8_quiet_state", 32'(run_state), 32'd0);
            check("t8_quiet_follow", 32'(display_follow), 32'd1);
            check("t8_quiet_tick", 32'(count_tick), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning clk cycles a key level must stay stable before it is accepted (20 ms at 50 MHz).
REQ-002 The block SHALL have parameter TICK_CYCLES, default 500000, meaning clk cycles per count_tick (10 ms at 50 MHz).
REQ-003 The block SHALL have port clk, input, width 1: the single system clock, 50 MHz; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port key_reset_n, input, width 1: raw board key, 0 = pressed; request clear.
REQ-006 The block SHALL have port key_start_pause_n, input, width 1: raw board key, 0 = pressed; request start/pause toggle.
REQ-007 The block SHALL have port key_display_stop_n, input, width 1: raw board key, 0 = pressed; request display freeze toggle.
REQ-008 The block SHALL have port count_tick, output, width 1: one-cycle enable pulse to the BCD time counters.
REQ-009 The block SHALL have port counter_clear, output, width 1: one-cycle pulse zeroing all BCD time counters.
REQ-010 The block SHALL have port display_follow, output, width 1: 1 = display registers load counters every cycle; 0 = display frozen.
REQ-011 The block SHALL have port run_state, output, width 2: current FSM state encoding.
REQ-012 The block SHALL have port led, output, width 4: status indicators, active-high.

Function
REQ-013 Each key input SHALL pass through a 2-flop synchronizer whose flops reset to 1.
REQ-014 An accepted key level SHALL change only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart that count.
REQ-015 A press event SHALL be a one-cycle pulse on an accepted 1->0 transition; release SHALL produce no event; a held key SHALL produce exactly one event.
REQ-016 A clean key edge SHALL produce its press event DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples the new level.
REQ-017 FSM states SHALL be IDLE=00, RUN=01, PAUSE=10; code 11 is unreachable and SHALL recover to IDLE.
REQ-018 A start event SHALL move IDLE->RUN, RUN->PAUSE and PAUSE->RUN.
REQ-019 A reset event SHALL move any state to IDLE and assert counter_clear for exactly the next cycle.
REQ-020 Tick counter SHALL increment only in RUN, and count_tick SHALL pulse on the cycle it equals TICK_CYCLES-1, when it SHALL wrap to 0.
REQ-021 In PAUSE the tick counter SHALL hold, so that the fractional period resumes on RUN.
REQ-022 In IDLE and on a reset event the tick counter SHALL clear to 0.
REQ-023 count_tick and counter_clear SHALL never be asserted in the same cycle; clear wins.
REQ-024 A display event SHALL toggle display_follow in any state.
REQ-025 A reset event SHALL force display_follow to 1.
REQ-026 When reset and start events coincide, reset SHALL win and start SHALL be ignored.
REQ-027 When reset and display events coincide, display_follow SHALL become 1.
REQ-028 When start and display events coincide, both SHALL take effect.
REQ-029 led SHALL be driven as: led[0]=RUN, led[1]=PAUSE, led[2]=~display_follow, led[3]=any accepted key level low; all registered.

Reset
REQ-030 On reset assertion, asynchronously: state=IDLE, tick counter=0, debounce counters=0, accepted levels=1, synchronizer flops=1.
REQ-031 On reset assertion, asynchronously: count_tick=0, counter_clear=0, display_follow=1, run_state=00, led=0000.
REQ-032 After reset deassertion with keys released, no press event SHALL occur.

Structure
REQ-033 A shared package stopwatch_pkg SHALL hold the state encodings and the default DEBOUNCE_CYCLES/TICK_CYCLES constants.
REQ-034 Synchronizer, debounce and edge detection SHALL be one sub-module, key_debounce, instantiated three times.
REQ-035 Counter widths SHALL be derived from the parameters via clog2.

Verification (DEBOUNCE_CYCLES=4, TICK_CYCLES=5)
REQ-036 Press start once, hold 20 cycles -> one event at +6 cycles, run_state 00->01, count_tick every 5 cycles thereafter.
REQ-037 Bounce start 1-0-1-0 with 2-cycle gaps, then hold low -> single event 6 cycles after last edge, no earlier event.
REQ-038 RUN 7 cycles past a tick, pause 10 cycles, resume -> next count_tick 3 cycles after resume.
REQ-039 Reset and start events in same cycle while in PAUSE -> run_state=00, counter_clear one cycle, no count_tick, display_follow=1.
REQ-040 Display press in RUN -> display_follow=0, led[2]=1; second press -> display_follow=1; ticks continue throughout.
REQ-041 Assert reset mid-debounce and mid-tick -> all outputs at reset values immediately; no event after release.
